// File: rtl/mant_align_pkg.sv
// Shared encodings and width helpers for the posit FMA mantissa alignment path.
package mant_align_pkg;

  localparam int unsigned LANE_W_DEF = 14;
  localparam int unsigned GRS_DEF    = 3;
  localparam int unsigned SHW_DEF    = 5;

  typedef enum logic [1:0] {
    PRE_4X14 = 2'b00,
    PRE_2X28 = 2'b01,
    PRE_1X56 = 2'b10
  } pre_e;

  // 2'b11 has no mode of its own and behaves as the single 56-bit segment.
  function automatic pre_e decode_pre(input logic [1:0] p);
    case (p)
      2'b00:   return PRE_4X14;
      2'b01:   return PRE_2X28;
      default: return PRE_1X56;
    endcase
  endfunction

  // Segment mantissa width at SIMD level lvl (0: 4 lanes, 1: 2 lanes, 2: 1 lane).
  function automatic int unsigned seg_w(input int unsigned lane_w, input int unsigned lvl);
    return lane_w << lvl;
  endfunction

  // Output slot group width owned by one segment at level lvl.
  function automatic int unsigned slot_w(input int unsigned lane_w, input int unsigned grs,
                                         input int unsigned lvl);
    return (lane_w + grs + 1) << lvl;
  endfunction

endpackage

// File: rtl/mant_seg_shift.sv
// Right shifter for one alignment segment: appends GRS zero bits, shifts, and
// collects the OR of everything shifted out; oversize shifts saturate to zero.
module mant_seg_shift #(
  parameter int unsigned W   = 14,
  parameter int unsigned GRS = 3,
  parameter int unsigned SW  = 5
) (
  input  logic [W-1:0]     opnd,
  input  logic [SW-1:0]    sh,
  output logic [W+GRS-1:0] opnd_x,
  output logic             sticky
);

  localparam int unsigned X = W + GRS;

  logic [X-1:0] ext;
  logic [X-1:0] lost_mask;

  always_comb begin
    ext       = {opnd, {GRS{1'b0}}};
    lost_mask = '0;
    opnd_x    = '0;
    sticky    = 1'b0;
    if (32'(sh) >= X) begin
      sticky = |opnd;
    end else begin
      lost_mask = ~({X{1'b1}} << sh);
      opnd_x    = ext >> sh;
      sticky    = |(ext & lost_mask);
    end
  end

endmodule

// File: rtl/mant_align_pipe.sv
// Two-stage SIMD mantissa align (swap, shift, sticky) and add/subtract with
// valid/ready flow control; 4x14, 2x28 or 1x56 segments selected per beat.
module mant_align_pipe
  import mant_align_pkg::*;
#(
  parameter int unsigned LANE_W = LANE_W_DEF,
  parameter int unsigned N_LANE = 4,
  parameter int unsigned GRS    = GRS_DEF,
  parameter int unsigned SHW    = SHW_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_LANE*LANE_W-1:0]        mant_E,
  input  logic [N_LANE*LANE_W-1:0]        mant_F,
  input  logic [N_LANE*SHW-1:0]           ctl,
  input  logic [N_LANE-1:0]               swap,
  input  logic [N_LANE-1:0]               sub,
  input  logic [1:0]                      in_pre,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_LANE*(LANE_W+GRS+1)-1:0] mant_sum,
  output logic [N_LANE-1:0]               sticky,
  output logic [1:0]                      out_pre
);

  localparam int unsigned XW   = LANE_W + GRS;
  localparam int unsigned FW   = N_LANE * XW;
  localparam int unsigned OW   = N_LANE * (LANE_W + GRS + 1);
  localparam int unsigned NLVL = 3;

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Stage 1: every SIMD level is aligned in parallel; the beat's mode picks one.
  // Segment j of a level sits at stride XW<<lvl in the shared stage-1 fields,
  // and its sticky/sub flags sit on the segment's lowest lane bit.
  for (genvar L = 0; L < NLVL; L++) begin : g_s1
    localparam int unsigned W  = seg_w(LANE_W, L);
    localparam int unsigned X  = W + GRS;
    localparam int unsigned SW = SHW << L;
    localparam int unsigned NS = N_LANE >> L;
    localparam int unsigned ST = XW << L;
    localparam int unsigned GL = 1 << L;

    logic [NS-1:0][X-1:0] big_x;
    logic [NS-1:0][X-1:0] small_x;
    logic [NS-1:0]        stk;
    logic [NS-1:0]        sb;
    logic [FW-1:0]        big_f;
    logic [FW-1:0]        small_f;
    logic [N_LANE-1:0]    stk_f;
    logic [N_LANE-1:0]    sub_f;

    for (genvar j = 0; j < NS; j++) begin : g_seg
      logic [W-1:0] e;
      logic [W-1:0] f;
      logic         sw;

      assign e        = mant_E[j*W +: W];
      assign f        = mant_F[j*W +: W];
      assign sw       = swap[j*GL + GL - 1];
      assign sb[j]    = sub[j*GL + GL - 1];
      assign big_x[j] = {(sw ? f : e), {GRS{1'b0}}};

      mant_seg_shift #(
        .W   (W),
        .GRS (GRS),
        .SW  (SW)
      ) u_shift (
        .opnd   (sw ? e : f),
        .sh     (ctl[j*SW +: SW]),
        .opnd_x (small_x[j]),
        .sticky (stk[j])
      );
    end

    always_comb begin
      big_f   = '0;
      small_f = '0;
      stk_f   = '0;
      sub_f   = '0;
      for (int unsigned j = 0; j < NS; j++) begin
        big_f[j*ST +: X]   = big_x[j];
        small_f[j*ST +: X] = small_x[j];
        stk_f[j*GL]        = stk[j];
        sub_f[j*GL]        = sb[j];
      end
    end
  end

  logic [FW-1:0]     d1_big, d1_small;
  logic [N_LANE-1:0] d1_stk, d1_sub;

  always_comb begin
    d1_big   = g_s1[2].big_f;
    d1_small = g_s1[2].small_f;
    d1_stk   = g_s1[2].stk_f;
    d1_sub   = g_s1[2].sub_f;
    case (decode_pre(in_pre))
      PRE_4X14: begin
        d1_big   = g_s1[0].big_f;
        d1_small = g_s1[0].small_f;
        d1_stk   = g_s1[0].stk_f;
        d1_sub   = g_s1[0].sub_f;
      end
      PRE_2X28: begin
        d1_big   = g_s1[1].big_f;
        d1_small = g_s1[1].small_f;
        d1_stk   = g_s1[1].stk_f;
        d1_sub   = g_s1[1].sub_f;
      end
      default: ;
    endcase
  end

  logic [FW-1:0]     s1_big, s1_small;
  logic [N_LANE-1:0] s1_stk, s1_sub;
  logic [1:0]        s1_pre;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_big   <= '0;
      s1_small <= '0;
      s1_stk   <= '0;
      s1_sub   <= '0;
      s1_pre   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_big   <= d1_big;
        s1_small <= d1_small;
        s1_stk   <= d1_stk;
        s1_sub   <= d1_sub;
        s1_pre   <= in_pre;
      end
    end
  end

  // Stage 2: subtraction also removes the sticky bit so the borrow lands in the MSB.
  for (genvar L = 0; L < NLVL; L++) begin : g_s2
    localparam int unsigned X  = seg_w(LANE_W, L) + GRS;
    localparam int unsigned NS = N_LANE >> L;
    localparam int unsigned ST = XW << L;
    localparam int unsigned GL = 1 << L;
    localparam int unsigned SL = slot_w(LANE_W, GRS, L);

    logic [NS-1:0][X:0] res;
    logic [OW-1:0]      sum_f;

    for (genvar j = 0; j < NS; j++) begin : g_seg
      logic [X-1:0] b;
      logic [X-1:0] s;
      logic         k;

      assign b = s1_big[j*ST +: X];
      assign s = s1_small[j*ST +: X];
      assign k = s1_stk[j*GL];
      assign res[j] = s1_sub[j*GL] ? ({1'b0, b} - {1'b0, s} - {{X{1'b0}}, k})
                                   : ({1'b0, b} + {1'b0, s});
    end

    always_comb begin
      sum_f = '0;
      for (int unsigned j = 0; j < NS; j++) begin
        sum_f[j*SL +: X+1] = res[j];
      end
    end
  end

  logic [OW-1:0] d2_sum;

  always_comb begin
    d2_sum = g_s2[2].sum_f;
    case (decode_pre(s1_pre))
      PRE_4X14: d2_sum = g_s2[0].sum_f;
      PRE_2X28: d2_sum = g_s2[1].sum_f;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      mant_sum <= '0;
      sticky   <= '0;
      out_pre  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        mant_sum <= d2_sum;
        sticky   <= s1_stk;
        out_pre  <= s1_pre;
      end
    end
  end

endmodule

// File: tb/tb_mant_align_pipe.sv
// Self-checking bench for mant_align_pipe: directed cases, backpressure, reset
// and randomized beats against an arithmetic reference model.
module tb_mant_align_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] mant_E;
  logic [55:0] mant_F;
  logic [19:0] ctl;
  logic [3:0]  swap;
  logic [3:0]  sub;
  logic [1:0]  in_pre;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] mant_sum;
  logic [3:0]  sticky;
  logic [1:0]  out_pre;

  always #5 clk = ~clk;

  mant_align_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_E    (mant_E),
    .mant_F    (mant_F),
    .ctl       (ctl),
    .swap      (swap),
    .sub       (sub),
    .in_pre    (in_pre),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_sum  (mant_sum),
    .sticky    (sticky),
    .out_pre   (out_pre)
  );

  typedef struct {
    logic [71:0] sum;
    logic [3:0]  st;
    logic [1:0]  pre;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned passed = 0;
  int unsigned total  = 0;
  bit          pending = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Reference: per segment, pick larger operand, scale by 8, shift the other,
  // then add or subtract modulo 2^(W+4) using 64-bit integers.
  function automatic beat_t model(input logic [55:0] e, input logic [55:0] f,
                                  input logic [19:0] c, input logic [3:0] sw,
                                  input logic [3:0] sb, input logic [1:0] p);
    beat_t           r;
    int unsigned     lvl, w, n, shw, slot, g;
    longint unsigned a, b, big, sml, bx, sx, sh, res;
    bit              s, do_sub;
    lvl = (p == 2'b00) ? 0 : (p == 2'b01) ? 1 : 2;
    w = 14 << lvl; n = 4 >> lvl; shw = 5 << lvl; slot = 18 << lvl; g = 1 << lvl;
    r.sum = '0; r.st = '0; r.pre = p;
    for (int unsigned j = 0; j < n; j++) begin
      a      = 64'(e >> (j * w)) & ((64'd1 << w) - 64'd1);
      b      = 64'(f >> (j * w)) & ((64'd1 << w) - 64'd1);
      sh     = 64'(c >> (j * shw)) & ((64'd1 << shw) - 64'd1);
      big    = sw[j*g+g-1] ? b : a;
      sml    = sw[j*g+g-1] ? a : b;
      do_sub = sb[j*g+g-1];
      bx     = big * 8;
      if (sh >= 64'(w + 3)) begin
        sx = 0;
        s  = (sml != 0);
      end else begin
        sx = (sml * 8) >> sh;
        s  = (((sml * 8) & ((64'd1 << sh) - 64'd1)) != 0);
      end
      res = do_sub ? (bx - sx - 64'(s)) : (bx + sx);
      res = res & ((64'd1 << (w + 4)) - 64'd1);
      for (int unsigned k = 0; k < w + 4; k++) r.sum[j*slot+k] = res[k];
      r.st[j*g] = s;
    end
    return r;
  endfunction

  function automatic beat_t lit(input logic [71:0] s, input logic [3:0] st, input logic [1:0] p);
    beat_t r;
    r.sum = s; r.st = st; r.pre = p;
    return r;
  endfunction

  // Output monitor: every visible beat is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0;
    end else begin
      if (pending) chk("valid_held", 72'(out_valid), 72'd1);
      pending = 0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 72'(out_valid), 72'd0);
        end else begin
          chk("mant_sum", mant_sum, exp_q[0].sum);
          chk("sticky", 72'(sticky), 72'(exp_q[0].st));
          chk("out_pre", 72'(out_pre), 72'(exp_q[0].pre));
          if (out_ready) void'(exp_q.pop_front());
          else pending = 1;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat's accepting edge.
  task automatic send(input logic [55:0] e, input logic [55:0] f, input logic [19:0] c,
                      input logic [3:0] sw, input logic [3:0] sb, input logic [1:0] p,
                      input beat_t x);
    int unsigned n = 0;
    bit          done = 0;
    mant_E = e; mant_F = f; ctl = c; swap = sw; sub = sb; in_pre = p; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(x);
        done = 1;
      end else if (++n > 50) begin
        chk("in_ready_timeout", 72'(in_ready), 72'd1);
        done = 1;
      end
      @(posedge clk); #1;
      if (!done) out_ready = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [1:0] p);
    logic [63:0]  re, rf;
    logic [19:0]  c;
    logic [3:0]   sw, sb;
    int unsigned  lvl, w, n, shw, sh;
    re = {$urandom(), $urandom()};
    rf = {$urandom(), $urandom()};
    sw = 4'($urandom());
    sb = 4'($urandom());
    lvl = (p == 2'b00) ? 0 : (p == 2'b01) ? 1 : 2;
    w = 14 << lvl; n = 4 >> lvl; shw = 5 << lvl;
    c = '0;
    for (int unsigned j = 0; j < n; j++) begin
      sh = ($urandom_range(0, 7) == 0) ? ((1 << shw) - 1) : $urandom_range(0, w + 6);
      c  = c | (20'(sh) << (j * shw));
    end
    send(re[55:0], rf[55:0], c, sw, sb, p, model(re[55:0], rf[55:0], c, sw, sb, p));
  endtask

  task automatic drain();
    int unsigned n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 72'(exp_q.size()), 72'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish before 500000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mant_E = '0; mant_F = '0; ctl = '0; swap = '0; sub = '0; in_pre = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 72'(out_valid), 72'd0);
    chk("rst_in_ready", 72'(in_ready), 72'd1);
    chk("rst_mant_sum", mant_sum, 72'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 4x14 plain add; result visible on the second edge after acceptance.
    send(56'h2000, 56'h2000, 20'd1, 4'b0000, 4'b0000, 2'b00, lit(72'h18000, 4'b0000, 2'b00));
    @(negedge clk);
    chk("lat_cycle1", 72'(out_valid), 72'd0);
    @(negedge clk);
    chk("lat_cycle2", 72'(out_valid), 72'd1);
    @(posedge clk); #1;

    // Saturated shift, subtract then add.
    send(56'h2000, 56'h0001, 20'd31, 4'b0000, 4'b0001, 2'b00, lit(72'h0FFFF, 4'b0001, 2'b00));
    send(56'h2000, 56'h0001, 20'd31, 4'b0000, 4'b0000, 2'b00, lit(72'h10000, 4'b0001, 2'b00));

    // 1x56, F larger; then equal-magnitude subtract in mode 11.
    send(56'h80000000000000, 56'h80000000000000, 20'd1, 4'b1000, 4'b0000, 2'b10,
         lit(72'h0600000000000000, 4'b0000, 2'b10));
    send(56'h80000000000000, 56'h80000000000000, 20'd0, 4'b1000, 4'b1000, 2'b11,
         lit(72'h0, 4'b0000, 2'b11));

    // 2x28: seg1 sticky from shifted-out bits, seg0 independent subtract.
    send(56'h8000000_1234567, 56'h0000007_0ABCDEF, 20'h01002, 4'b0000, 4'b0010, 2'b01,
         lit(72'h040000003007C28F5A, 4'b0100, 2'b01));
    send(56'h8000000_0000000, 56'h0000007_0000000, 20'h01000, 4'b0000, 4'b0000, 2'b01,
         lit(72'h040000003000000000, 4'b0100, 2'b01));
    drain();

    // Backpressure: two beats fill the pipe, the third must wait.
    out_ready = 1'b0;
    send_rand(2'b00);
    send_rand(2'b01);
    mant_E = '0; mant_F = '0; ctl = '0; swap = '0; sub = '0; in_pre = 2'b00; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 72'(in_ready), 72'd0);
      @(posedge clk); #1;
    end
    send_rand(2'b10);
    send_rand(2'b00);
    drain();

    // Reset with both stages occupied discards the in-flight beats.
    out_ready = 1'b0;
    send_rand(2'b01);
    send_rand(2'b00);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_out_valid", 72'(out_valid), 72'd0);
    chk("rst2_in_ready", 72'(in_ready), 72'd1);
    chk("rst2_mant_sum", mant_sum, 72'd0);
    chk("rst2_sticky", 72'(sticky), 72'd0);
    chk("rst2_out_pre", 72'(out_pre), 72'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Randomized beats with random downstream stalls and input gaps.
    for (int unsigned i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      send_rand(2'($urandom()));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
